// File: rtl/game_pkg.sv
`default_nettype none
// ==== game_pkg -- shared game state encoding and tile-type constants (rev 1.0) ====
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } game_state_t;

  localparam logic [1:0] c_BACKGROUND = 2'b00;
  localparam logic [1:0] c_FLOOR      = 2'b01;
  localparam logic [1:0] c_GIFT       = 2'b10;
  localparam logic [1:0] c_HOLE       = 2'b11;

endpackage
`default_nettype wire

// File: rtl/frame_second_timer.sv
`default_nettype none
// ==== frame_second_timer -- frame-driven level countdown in seconds (rev 1.0) ====
module frame_second_timer #(
  parameter int FRAMES_PER_SEC = 30,
  parameter int TIME_LIMIT_SEC = 60
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       load,
  input  logic       enable,
  input  logic       startOfFrame,
  output logic [6:0] secondsLeft,
  output logic       expired
);

  localparam int             FW     = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0]  c_LAST  = FW'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]     c_LIMIT = 7'(TIME_LIMIT_SEC);

  logic [FW-1:0] r_frameCnt;
  logic [6:0]    r_secs;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frameCnt <= '0;
      r_secs     <= c_LIMIT;
    end else if (load) begin
      r_frameCnt <= '0;
      r_secs     <= c_LIMIT;
    end else if (enable && startOfFrame) begin
      if (r_frameCnt == c_LAST) begin
        r_frameCnt <= '0;
        // Saturate: the countdown never wraps below zero
        if (r_secs != 7'd0) r_secs <= r_secs - 7'd1;
      end else begin
        r_frameCnt <= r_frameCnt + FW'(1);
      end
    end
  end

  assign secondsLeft = r_secs;
  assign expired     = (r_secs == 7'd0);

endmodule
`default_nettype wire

// File: rtl/game_flow_manager.sv
`default_nettype none
// ==== game_flow_manager -- level flow FSM, event latching and gift counter (rev 1.0) ====
module game_flow_manager
  import game_pkg::*;
#(
  parameter int NUM_GIFTS      = 5,
  parameter int TIME_LIMIT_SEC = 60,
  parameter int FRAMES_PER_SEC = 30
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       Remove_Gift,
  input  logic       victory,
  input  logic       Loss,
  output logic [1:0] gameState,
  output logic [3:0] giftsLeft,
  output logic [6:0] secondsLeft,
  output logic       gift_clear,
  output logic       finishCount,
  output logic       removeGiftPulse,
  output logic       levelRestart
);

  localparam logic [3:0] c_GIFTS = 4'(NUM_GIFTS);

  game_state_t r_state, w_stateNext;
  logic        r_startPrev, w_startEdge;
  logic        r_pendGift, r_pendWin, r_pendLoss;
  logic        w_pendGift, w_pendWin, w_pendLoss;
  logic [3:0]  r_giftsLeft;
  logic        r_giftClear, r_finish, r_removePulse, r_levelRestart;
  logic        w_load, w_giftDec, w_inPlay, w_expired;

  assign w_startEdge = startKey & ~r_startPrev;
  assign w_inPlay    = (r_state == PLAY);
  // Events arriving on the boundary cycle itself are folded into that boundary
  assign w_pendGift  = w_inPlay & (r_pendGift | Remove_Gift);
  assign w_pendWin   = w_inPlay & (r_pendWin  | victory);
  assign w_pendLoss  = w_inPlay & (r_pendLoss | Loss);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_giftDec   = 1'b0;
    case (r_state)
      IDLE: if (w_startEdge) begin
        w_stateNext = PLAY;
        w_load      = 1'b1;
      end
      PLAY: if (startOfFrame) begin
        // The hole only goes live once gift_clear is already visible
        if (w_pendLoss)                     w_stateNext = LOSE;
        else if (w_pendWin && r_giftClear)  w_stateNext = WIN;
        if (w_pendGift && (r_giftsLeft != 4'd0)) w_giftDec = 1'b1;
      end
      WIN, LOSE: if (w_startEdge) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_startPrev    <= 1'b0;
      r_pendGift     <= 1'b0;
      r_pendWin      <= 1'b0;
      r_pendLoss     <= 1'b0;
      r_giftsLeft    <= c_GIFTS;
      r_giftClear    <= 1'b0;
      r_finish       <= 1'b0;
      r_removePulse  <= 1'b0;
      r_levelRestart <= 1'b0;
    end else begin
      r_startPrev <= startKey;
      if (!w_inPlay || startOfFrame) begin
        r_pendGift <= 1'b0;
        r_pendWin  <= 1'b0;
        r_pendLoss <= 1'b0;
      end else begin
        r_pendGift <= w_pendGift;
        r_pendWin  <= w_pendWin;
        r_pendLoss <= w_pendLoss;
      end
      if (w_load)         r_giftsLeft <= c_GIFTS;
      else if (w_giftDec) r_giftsLeft <= r_giftsLeft - 4'd1;
      r_giftClear    <= ~w_load & (r_giftsLeft == 4'd0);
      r_finish       <= (w_stateNext == PLAY) & ~w_load & w_expired;
      r_removePulse  <= w_giftDec;
      r_levelRestart <= w_load;
    end
  end

  frame_second_timer #(
    .FRAMES_PER_SEC (FRAMES_PER_SEC),
    .TIME_LIMIT_SEC (TIME_LIMIT_SEC)
  ) u_timer (
    .clk          (clk),
    .resetN       (resetN),
    .load         (w_load),
    .enable       (w_inPlay),
    .startOfFrame (startOfFrame),
    .secondsLeft  (secondsLeft),
    .expired      (w_expired)
  );

  assign gameState       = r_state;
  assign giftsLeft       = r_giftsLeft;
  assign gift_clear      = r_giftClear;
  assign finishCount     = r_finish;
  assign removeGiftPulse = r_removePulse;
  assign levelRestart    = r_levelRestart;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_manager.sv
`default_nettype none
// ==== tb_game_flow_manager -- directed self-checking bench for game_flow_manager (rev 1.0) ====
module tb_game_flow_manager;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       startKey = 1'b0;
  logic       Remove_Gift = 1'b0;
  logic       victory = 1'b0;
  logic       Loss = 1'b0;
  logic [1:0] gameState;
  logic [3:0] giftsLeft;
  logic [6:0] secondsLeft;
  logic       gift_clear, finishCount, removeGiftPulse, levelRestart;

  int n_tests = 0;
  int n_fail  = 0;
  int rgp_cnt = 0;
  int lr_cnt  = 0;
  int base;

  game_flow_manager #(
    .NUM_GIFTS      (2),
    .TIME_LIMIT_SEC (3),
    .FRAMES_PER_SEC (4)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .startKey        (startKey),
    .Remove_Gift     (Remove_Gift),
    .victory         (victory),
    .Loss            (Loss),
    .gameState       (gameState),
    .giftsLeft       (giftsLeft),
    .secondsLeft     (secondsLeft),
    .gift_clear      (gift_clear),
    .finishCount     (finishCount),
    .removeGiftPulse (removeGiftPulse),
    .levelRestart    (levelRestart)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (removeGiftPulse) rgp_cnt++;
    if (levelRestart)    lr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  task automatic press();
    startKey = 1'b1;
    step();
    startKey = 1'b0;
  endtask

  initial begin
    // Reset values
    idle(3);
    chk("rst_state", gameState, 0);
    chk("rst_gifts", giftsLeft, 2);
    chk("rst_secs", secondsLeft, 3);
    chk("rst_strobes", {gift_clear, finishCount, removeGiftPulse, levelRestart}, 0);
    resetN = 1'b1;
    idle(2);
    chk("idle_hold", gameState, 0);

    // Start: one edge even when the key is held
    base = lr_cnt;
    startKey = 1'b1;
    step();
    chk("start_state", gameState, 1);
    chk("start_lr", levelRestart, 1);
    chk("start_gifts", giftsLeft, 2);
    chk("start_secs", secondsLeft, 3);
    idle(5);
    startKey = 1'b0;
    step();
    chk("start_lr_once", lr_cnt - base, 1);
    chk("start_still_play", gameState, 1);

    // Frame 1: early win rejected
    victory = 1'b1; idle(3); victory = 1'b0; idle(2);
    frame();
    chk("early_win_state", gameState, 1);
    chk("early_win_gifts", giftsLeft, 2);

    // Frame 2: gift held 50 cycles counts once
    base = rgp_cnt;
    Remove_Gift = 1'b1; idle(50); Remove_Gift = 1'b0; idle(2);
    frame();
    chk("gift1_left", giftsLeft, 1);
    chk("gift1_pulse", removeGiftPulse, 1);
    step();
    chk("gift1_pulse_end", removeGiftPulse, 0);
    chk("gift1_pulse_cnt", rgp_cnt - base, 1);

    // Frame 3: last gift plus victory in the same frame
    Remove_Gift = 1'b1; victory = 1'b1; idle(4);
    Remove_Gift = 1'b0; victory = 1'b0; idle(1);
    frame();
    chk("gift2_left", giftsLeft, 0);
    chk("gift2_state", gameState, 1);
    chk("gift2_clear_lag", gift_clear, 0);
    step();
    chk("gift2_clear", gift_clear, 1);

    // Frame 4: hole is live now
    victory = 1'b1; idle(2); victory = 1'b0;
    frame();
    chk("win_state", gameState, 2);
    Remove_Gift = 1'b1; idle(2);
    frame();
    Remove_Gift = 1'b0;
    chk("win_ignore_gift", giftsLeft, 0);
    chk("win_finish", finishCount, 0);

    // Back to IDLE, then a new level for the time-out
    press();
    chk("win_to_idle", gameState, 0);
    idle(2);
    press();
    chk("lvl2_state", gameState, 1);
    chk("lvl2_gifts", giftsLeft, 2);
    chk("lvl2_secs", secondsLeft, 3);
    for (int f = 1; f <= 12; f++) begin
      idle(2);
      frame();
      if (f == 4)  chk("tmo_secs_f4", secondsLeft, 2);
      if (f == 8)  chk("tmo_secs_f8", secondsLeft, 1);
      if (f == 11) chk("tmo_finish_early", finishCount, 0);
    end
    chk("tmo_secs_zero", secondsLeft, 0);
    step();
    chk("tmo_finish", finishCount, 1);
    chk("tmo_still_play", gameState, 1);
    idle(2);
    Loss = finishCount;
    frame();
    Loss = 1'b0;
    chk("tmo_lose", gameState, 3);
    chk("tmo_finish_off", finishCount, 0);

    // Priority: loss beats a live win
    press(); idle(1); press();
    chk("lvl3_state", gameState, 1);
    Remove_Gift = 1'b1; step(); Remove_Gift = 1'b0; frame();
    Remove_Gift = 1'b1; step(); Remove_Gift = 1'b0; frame();
    step();
    chk("lvl3_clear", gift_clear, 1);
    Loss = 1'b1; victory = 1'b1;
    frame();
    Loss = 1'b0; victory = 1'b0;
    chk("prio_loss_win", gameState, 3);

    // Priority: loss with gift still decrements and pulses
    press(); idle(1); press();
    base = rgp_cnt;
    Loss = 1'b1; Remove_Gift = 1'b1;
    frame();
    Loss = 1'b0; Remove_Gift = 1'b0;
    chk("prio_loss_gift_state", gameState, 3);
    chk("prio_loss_gift_left", giftsLeft, 1);
    idle(2);
    chk("prio_loss_gift_pulse", rgp_cnt - base, 1);

    // Reset mid-play
    press(); idle(1); press();
    Remove_Gift = 1'b1; step(); Remove_Gift = 1'b0;
    frame(); frame(); frame(); frame();
    chk("mid_gifts", giftsLeft, 1);
    chk("mid_secs", secondsLeft, 2);
    #2 resetN = 1'b0;
    #1;
    chk("mid_rst_state", gameState, 0);
    chk("mid_rst_gifts", giftsLeft, 2);
    chk("mid_rst_secs", secondsLeft, 3);
    chk("mid_rst_strobes", {gift_clear, finishCount, removeGiftPulse, levelRestart}, 0);
    step();
    resetN = 1'b1;
    idle(2);
    chk("post_rst_idle", gameState, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_flow_manager.md
Name: game_flow_manager

Overview:
- Consumes per-pixel event flags from the collision/game controller (Remove_Gift, victory, Loss) and runs the level flow: idle, play, win, lose.
- Owns the gift counter and the level countdown timer.
- Drives gift_clear and finishCount back into the game controller.
- Raises exactly one frame-qualified strobe per gift pickup for the gift-map / score logic.

Parameters:
- NUM_GIFTS, 5, gifts placed per level; must be 1..15.
- TIME_LIMIT_SEC, 60, level time budget in seconds; must be 1..127.
- FRAMES_PER_SEC, 30, startOfFrame pulses per second.

Ports:
- clk  in  1  system clock
- resetN  in  1  async active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- startKey  in  1  level from keypad; rising edge is a start/continue request
- Remove_Gift  in  1  per-pixel: ball over gift tile
- victory  in  1  per-pixel: ball over hole tile
- Loss  in  1  per-pixel: out-of-map or time-out
- gameState  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE
- giftsLeft  out  4  remaining gifts
- secondsLeft  out  7  remaining seconds
- gift_clear  out  1  giftsLeft==0
- finishCount  out  1  time expired while in PLAY
- removeGiftPulse  out  1  one-cycle pulse per accepted pickup
- levelRestart  out  1  one-cycle pulse on IDLE->PLAY

Behaviour:
- Reset (async, resetN=0) sets:
  - gameState=IDLE, giftsLeft=NUM_GIFTS, secondsLeft=TIME_LIMIT_SEC, frame counter=0.
  - gift_clear, finishCount, removeGiftPulse, levelRestart all 0.
  - All pending flags and the startKey edge register cleared.
- Reset mid-level aborts to IDLE with the same values.
- startKey edge:
  - Prev-value register; startEdge = startKey & ~prev.
  - Holding the key gives one edge only.
- Event latching:
  - In PLAY, any cycle with Remove_Gift/victory/Loss=1 sets pendGift/pendWin/pendLoss (sticky).
  - All three flags are evaluated and cleared on startOfFrame.
  - If an event arrives in the same cycle as startOfFrame, it is evaluated at that boundary.
- Frame boundary resolution (startOfFrame, state PLAY):
  - Priority: pendLoss > pendWin > pendGift.
  - pendLoss: go to LOSE.
  - pendWin: go to WIN only if gift_clear is already 1 at that boundary. Otherwise discard; the hole is not yet live.
  - pendGift with giftsLeft>0: giftsLeft-1, removeGiftPulse=1 for exactly that cycle.
  - pendGift with giftsLeft==0: discard, no pulse.
  - gift_clear is registered: (giftsLeft==0), visible 1 cycle after the decrement. A win latched in the same frame as the last pickup is therefore discarded; the player must re-enter the hole.
  - Loss and gift in the same frame: LOSE, and the gift is still decremented/pulsed.
- Timer (PLAY only, on startOfFrame):
  - frameCnt counts 0..FRAMES_PER_SEC-1; on wrap, secondsLeft-1 (saturates at 0).
  - finishCount is registered: 1 iff state==PLAY and secondsLeft==0.
  - The controller returns finishCount as Loss, which gives LOSE at the following startOfFrame.
- FSM:
  - IDLE, startEdge: PLAY. Reload giftsLeft/secondsLeft/frameCnt, levelRestart=1 for one cycle, clear pending flags.
  - PLAY: transitions as above. startEdge is ignored.
  - WIN/LOSE: counters frozen, finishCount=0. On startEdge go to IDLE.
  - Outside PLAY, event inputs are ignored and pending flags are held at 0.
- Widths:
  - giftsLeft is 4-bit unsigned; secondsLeft is 7-bit unsigned.
  - frameCnt uses $clog2(FRAMES_PER_SEC) bits.
  - No wrap below 0.

Decomposition:
- Shared package game_pkg holds:
  - gameState enum (IDLE/PLAY/WIN/LOSE, 2-bit encoding above).
  - Tile-type constants BACKGROUND=00, FLOOR=01, GIFT=10, HOLE=11, shared with the controller.
- Sub-module frame_second_timer:
  - Inputs: clk, resetN, load, enable, startOfFrame.
  - Outputs: secondsLeft, expired.
  - Parameters: FRAMES_PER_SEC, TIME_LIMIT_SEC.
- FSM, event latching and gift counter stay in game_flow_manager.

Test Plan (NUM_GIFTS=2, TIME_LIMIT_SEC=3, FRAMES_PER_SEC=4):
- Start: release reset, pulse startKey -> gameState 00->01, levelRestart exactly 1 cycle, giftsLeft=2, secondsLeft=3.
- Gift debounce: Remove_Gift high 50 cycles within one frame -> at next startOfFrame giftsLeft=1, removeGiftPulse exactly 1 cycle; repeat next frame -> giftsLeft=0, gift_clear=1 one cycle later.
- Early win rejected: victory with giftsLeft=2 -> stays PLAY. Victory in the frame of the last pickup -> stays PLAY. Victory next frame -> WIN (10).
- Time-out: no events, 12 startOfFrame pulses -> secondsLeft 3->0, finishCount=1. Drive Loss=finishCount -> LOSE (11) at next frame, finishCount=0.
- Priority: Loss and victory (gift_clear=1) in the same frame -> LOSE. Loss and Remove_Gift in the same frame -> LOSE, giftsLeft decremented, one removeGiftPulse.
- Reset mid-play: resetN=0 while PLAY with giftsLeft=1, secondsLeft=2 -> immediately IDLE, giftsLeft=2, secondsLeft=3, all strobes 0.
